// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate L1 data cache with whole-line refill/evict via the arbiter.
// Define DCACHE_WRITE_THROUGH_EN to build the write-through variant (no dirty bits, every store writes its line).
module data_cache #(
    parameter int NUM_LINES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         wenable,
    input  logic [63:0]  addr,
    output logic [63:0]  rdata,
    input  logic [63:0]  wdata,
    output logic         done,
    output logic         drequest,
    input  logic         dreqack,
    output logic         dwrenable,
    output logic [63:0]  daddr,
    input  logic [511:0] drdata,
    output logic [511:0] dwdata,
    input  logic         ddone
);

    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 58 - IDX;

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_WAIT,
        FILL_REQ,
        FILL_WAIT,
        RESP
    } state_t;

    state_t state;

    logic [2:0]       word_sel;
    logic [8:0]       word_lsb;
    logic [IDX-1:0]   index;
    logic [TAG_W-1:0] tag;
    logic [63:0]      fill_addr;
    logic             unused_addr_bits;

    assign word_sel         = addr[5:3];
    assign word_lsb         = {word_sel, 6'b0};
    assign index            = addr[6 +: IDX];
    assign tag              = addr[63 -: TAG_W];
    assign fill_addr        = {addr[63:6], 6'b0};
    assign unused_addr_bits = ^addr[2:0];

    logic [NUM_LINES-1:0] valid_q;
`ifndef DCACHE_WRITE_THROUGH_EN
    logic [NUM_LINES-1:0] dirty_q;
    logic [63:0]          victim_addr;
`endif
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [511:0]         line_q [NUM_LINES];

    logic         hit;
    logic         hit_fire;
    logic         fill_fire;
    logic         wb_fire;
    logic         access_fire;
    logic [511:0] base_line;
    logic [511:0] merged_line;
    logic [63:0]  base_word;

    // A hit in IDLE and a completing fill share one access path: the line
    // being accessed is either the cached copy or the incoming refill.
    always_comb begin
        hit         = valid_q[index] && (tag_q[index] == tag);
        hit_fire    = (state == IDLE) && enable && hit;
        fill_fire   = ((state == FILL_REQ) && dreqack && ddone) ||
                      ((state == FILL_WAIT) && ddone);
        wb_fire     = ((state == WB_REQ) && dreqack && ddone) ||
                      ((state == WB_WAIT) && ddone);
        access_fire = hit_fire || fill_fire;
        base_line   = (state == IDLE) ? line_q[index] : drdata;
        base_word   = base_line[word_lsb +: 64];
        merged_line = base_line;
        if (wenable) begin
            merged_line[word_lsb +: 64] = wdata;
        end
    end

`ifndef DCACHE_WRITE_THROUGH_EN
    assign victim_addr = {tag_q[index], index, 6'b0};
`endif

    // Tag and data arrays carry no reset; only the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (access_fire && (wenable || fill_fire)) begin
            line_q[index] <= merged_line;
            tag_q[index]  <= tag;
        end
    end

    // Main controller. The per-state case handles handshakes; the completion
    // events below it override the next state when a transfer or access finishes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            valid_q   <= '0;
`ifndef DCACHE_WRITE_THROUGH_EN
            dirty_q   <= '0;
`endif
            done      <= 1'b0;
            drequest  <= 1'b0;
            dwrenable <= 1'b0;
            rdata     <= '0;
            daddr     <= '0;
            dwdata    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !hit) begin
`ifdef DCACHE_WRITE_THROUGH_EN
                        state     <= FILL_REQ;
                        drequest  <= 1'b1;
                        dwrenable <= 1'b0;
                        daddr     <= fill_addr;
`else
                        if (valid_q[index] && dirty_q[index]) begin
                            state     <= WB_REQ;
                            drequest  <= 1'b1;
                            dwrenable <= 1'b1;
                            daddr     <= victim_addr;
                            dwdata    <= line_q[index];
                        end else begin
                            state     <= FILL_REQ;
                            drequest  <= 1'b1;
                            dwrenable <= 1'b0;
                            daddr     <= fill_addr;
                        end
`endif
                    end
                end
                WB_REQ: begin
                    if (dreqack) begin
                        drequest <= 1'b0;
                        state    <= WB_WAIT;
                    end
                end
                FILL_REQ: begin
                    if (dreqack) begin
                        drequest <= 1'b0;
                        state    <= FILL_WAIT;
                    end
                end
                WB_WAIT, FILL_WAIT: begin
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (wb_fire) begin
`ifdef DCACHE_WRITE_THROUGH_EN
                done      <= 1'b1;
                state     <= RESP;
`else
                state     <= FILL_REQ;
                drequest  <= 1'b1;
                dwrenable <= 1'b0;
                daddr     <= fill_addr;
`endif
            end

            if (fill_fire) begin
                valid_q[index] <= 1'b1;
`ifndef DCACHE_WRITE_THROUGH_EN
                dirty_q[index] <= 1'b0;
`endif
            end

            if (access_fire) begin
                if (!wenable) begin
                    rdata <= base_word;
                    done  <= 1'b1;
                    state <= RESP;
                end else begin
`ifdef DCACHE_WRITE_THROUGH_EN
                    state     <= WB_REQ;
                    drequest  <= 1'b1;
                    dwrenable <= 1'b1;
                    daddr     <= fill_addr;
                    dwdata    <= merged_line;
`else
                    dirty_q[index] <= 1'b1;
                    done           <= 1'b1;
                    state          <= RESP;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_data_cache.sv
// Scoreboard bench for data_cache: a behavioural arbiter/memory plus an architectural word model.
// Expected responses and line transfers are queued at stimulus time and popped as the DUT produces them.
module tb_data_cache;

    localparam int NUM_LINES = 64;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic         wenable;
    logic [63:0]  addr;
    logic [63:0]  rdata;
    logic [63:0]  wdata;
    logic         done;
    logic         drequest;
    logic         dreqack;
    logic         dwrenable;
    logic [63:0]  daddr;
    logic [511:0] drdata;
    logic [511:0] dwdata;
    logic         ddone;

    data_cache #(.NUM_LINES(NUM_LINES)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wenable   (wenable),
        .addr      (addr),
        .rdata     (rdata),
        .wdata     (wdata),
        .done      (done),
        .drequest  (drequest),
        .dreqack   (dreqack),
        .dwrenable (dwrenable),
        .daddr     (daddr),
        .drdata    (drdata),
        .dwdata    (dwdata),
        .ddone     (ddone)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic        is_load;
        logic [63:0] data;
    } resp_t;

    typedef struct {
        logic        is_write;
        logic [63:0] addr;
        int          word;
        logic [63:0] data;
    } xfer_t;

    resp_t resp_q[$];
    xfer_t xfer_q[$];

    bit check_traffic = 1'b1;
    bit same_cycle    = 1'b0;
    int fill_latency  = 2;
    int xfer_count    = 0;
    int cycle         = 0;
    int ddone_edge    = 0;
    int done_edge     = 0;
    int req_edge      = 0;

    // Initial memory image; word 1 of line 0x1000 carries the known pattern.
    function automatic logic [63:0] init_word(input logic [63:0] a);
        logic [63:0] w;
        w = {a[63:3], 3'b0};
        if (w == 64'h1008) return 64'hDEADBEEF;
        return w ^ 64'h5A5A_0000_0000_0000 ^ (w << 20);
    endfunction

    function automatic logic [511:0] init_line(input logic [63:0] la);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[64*i +: 64] = init_word(la + 64'(8*i));
        return l;
    endfunction

    logic [63:0] ref_mem [logic [63:0]];

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] w;
        w = {a[63:3], 3'b0};
        if (ref_mem.exists(w)) return ref_mem[w];
        return init_word(w);
    endfunction

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (ddone) ddone_edge <= cycle + 1;
    end

    // Behavioural arbiter: acks one negedge after seeing a request, then
    // returns ddone after fill_latency cycles (or together with the ack).
    logic [511:0] mem [logic [63:0]];
    logic [63:0]  arb_addr;
    logic         arb_write;
    logic [511:0] arb_line;
    bit           arb_aborted;
    xfer_t        arb_exp;

    initial begin
        dreqack = 1'b0;
        ddone   = 1'b0;
        drdata  = '0;
        forever begin
            @(negedge clk);
            if (drequest && !reset) begin
                arb_addr  = daddr;
                arb_write = dwrenable;
                xfer_count++;
                if (check_traffic) begin
                    check_output("xfer_expected", 64'(xfer_q.size() != 0), 64'd1);
                    if (xfer_q.size() != 0) begin
                        arb_exp = xfer_q.pop_front();
                        check_output("xfer_dir", 64'(arb_write), 64'(arb_exp.is_write));
                        check_output("xfer_addr", arb_addr, arb_exp.addr);
                        if (arb_exp.is_write)
                            check_output("wb_word", dwdata[64*arb_exp.word +: 64], arb_exp.data);
                    end
                end
                if (arb_write) mem[arb_addr] = dwdata;
                arb_line = mem.exists(arb_addr) ? mem[arb_addr] : init_line(arb_addr);
                dreqack  = 1'b1;
                if (same_cycle) begin
                    drdata = arb_line;
                    ddone  = 1'b1;
                    @(negedge clk);
                    dreqack = 1'b0;
                    ddone   = 1'b0;
                end else begin
                    @(negedge clk);
                    dreqack     = 1'b0;
                    arb_aborted = 1'b0;
                    for (int i = 0; i < fill_latency; i++) begin
                        @(negedge clk);
                        if (reset) begin
                            arb_aborted = 1'b1;
                            break;
                        end
                    end
                    if (!arb_aborted) begin
                        drdata = arb_line;
                        ddone  = 1'b1;
                        @(negedge clk);
                        ddone = 1'b0;
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input bit is_store, input logic [63:0] a, input logic [63:0] d);
        resp_t r;
        @(negedge clk);
        addr     = a;
        wdata    = d;
        wenable  = is_store;
        enable   = 1'b1;
        req_edge = cycle + 1;
        r.is_load = !is_store;
        r.data    = is_store ? 64'd0 : ref_read(a);
        if (is_store) ref_mem[{a[63:3], 3'b0}] = d;
        resp_q.push_back(r);
    endtask

    task automatic wait_done();
        resp_t r;
        bit    seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen      = 1'b1;
                done_edge = cycle;
                break;
            end
        end
        check_output("done_seen", 64'(done), 64'd1);
        enable = 1'b0;
        if (resp_q.size() != 0) begin
            r = resp_q.pop_front();
            if (seen && r.is_load) check_output("rdata", rdata, r.data);
        end
        @(posedge clk);
        #1;
        check_output("done_pulse", 64'(done), 64'd0);
    endtask

    int x0;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        wenable = 1'b0;
        addr    = '0;
        wdata   = '0;
        repeat (3) @(negedge clk);
        check_output("rst_done", 64'(done), 64'd0);
        check_output("rst_drequest", 64'(drequest), 64'd0);
        check_output("rst_dwrenable", 64'(dwrenable), 64'd0);
        check_output("rst_rdata", rdata, 64'd0);
        check_output("rst_daddr", daddr, 64'd0);
        check_output("rst_dwdata", dwdata[63:0], 64'd0);
        reset = 1'b0;

        // Cold miss: fill read of line 0x1000, done on the edge sampling ddone.
        x0 = xfer_count;
        xfer_q.push_back('{1'b0, 64'h1000, 0, 64'd0});
        apply_stimulus(1'b0, 64'h1008, 64'd0);
        wait_done();
        check_output("miss_done_latency", 64'(done_edge - ddone_edge), 64'd0);
        check_output("miss_xfers", 64'(xfer_count - x0), 64'd1);

        // Same load hits: done right after the enable edge, no traffic.
        x0 = xfer_count;
        apply_stimulus(1'b0, 64'h1008, 64'd0);
        wait_done();
        check_output("hit_latency", 64'(done_edge - req_edge), 64'd0);
        check_output("hit_xfers", 64'(xfer_count - x0), 64'd0);

        // Store hit then load hit on word 2.
        x0 = xfer_count;
        apply_stimulus(1'b1, 64'h1010, 64'h1234);
        wait_done();
        check_output("store_hit_latency", 64'(done_edge - req_edge), 64'd0);
        apply_stimulus(1'b0, 64'h1010, 64'd0);
        wait_done();
        check_output("store_load_xfers", 64'(xfer_count - x0), 64'd0);

        // Conflicting index evicts the dirty line before refilling.
        x0 = xfer_count;
        xfer_q.push_back('{1'b1, 64'h1000, 2, 64'h1234});
        xfer_q.push_back('{1'b0, 64'h1000 + 64'(64 * NUM_LINES), 0, 64'd0});
        apply_stimulus(1'b0, 64'h1000 + 64'(64 * NUM_LINES), 64'd0);
        wait_done();
        check_output("evict_xfers", 64'(xfer_count - x0), 64'd2);
        check_output("evict_done_latency", 64'(done_edge - ddone_edge), 64'd0);

        // dreqack and ddone together during a fill.
        same_cycle = 1'b1;
        xfer_q.push_back('{1'b0, 64'h1040, 0, 64'd0});
        apply_stimulus(1'b0, 64'h1048, 64'd0);
        wait_done();
        check_output("same_cycle_latency", 64'(done_edge - ddone_edge), 64'd0);
        same_cycle = 1'b0;

        // Random loads/stores over conflicting lines, checked against the word model.
        check_traffic = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            a = 64'h8000 + 64'($urandom_range(0, 3) * 4096) + 64'($urandom_range(0, 3) * 64)
                + 64'($urandom_range(0, 7) * 8);
            apply_stimulus(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
            wait_done();
        end
        apply_stimulus(1'b0, 64'h1010, 64'd0);
        wait_done();
        check_traffic = 1'b1;

        // Reset while the fill is outstanding, then the same load must miss again.
        fill_latency = 20;
        x0 = xfer_count;
        xfer_q.push_back('{1'b0, 64'h30_0400, 0, 64'd0});
        apply_stimulus(1'b0, 64'h30_0408, 64'd0);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (xfer_count != x0 && !drequest) break;
        end
        check_output("fill_wait_reached", 64'(xfer_count - x0), 64'd1);
        @(negedge clk);
        reset  = 1'b1;
        enable = 1'b0;
        #1;
        check_output("rst_mid_drequest", 64'(drequest), 64'd0);
        check_output("rst_mid_done", 64'(done), 64'd0);
        resp_q.delete();
        repeat (3) @(negedge clk);
        reset        = 1'b0;
        fill_latency = 2;
        x0 = xfer_count;
        xfer_q.push_back('{1'b0, 64'h30_0400, 0, 64'd0});
        apply_stimulus(1'b0, 64'h30_0408, 64'd0);
        wait_done();
        check_output("refetch_xfers", 64'(xfer_count - x0), 64'd1);
        check_output("xfer_q_drained", 64'(xfer_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the core's MEM stage and the memory arbiter.
- Serves one 64-bit aligned load or store at a time.
- Refills and evicts whole 64-byte lines through the arbiter's data port.

Parameters:
- NUM_LINES, 64, number of cache lines; power of two, >=2. IDX = log2(NUM_LINES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  CPU request valid; held high until done.
- wenable  in  1  1 = store, 0 = load; stable while enable.
- addr  in  64  byte address; bits[2:0] ignored (word-aligned access).
- rdata  out  64  load data; valid in the cycle done=1.
- wdata  in  64  store data; stable while enable.
- done  out  1  one-cycle completion pulse.
- drequest  out  1  line transfer request to arbiter.
- dreqack  in  1  arbiter accepted the request (pulse).
- dwrenable  out  1  1 = line write to memory, 0 = line read.
- daddr  out  64  line address, bits[5:0]=0.
- drdata  in  512  refill line; valid when ddone=1.
- dwdata  out  512  evicted line; held stable while drequest.
- ddone  in  1  memory transfer complete (pulse).

Behaviour:
- Address split: word = addr[5:3]; index = addr[6+IDX-1:6]; tag = addr[63:6+IDX].
- Line layout: word i occupies line bits [64*i+63 : 64*i], little-endian.
- Per line storage: valid bit, dirty bit, tag, 512-bit data.
- Reset (async, any time, including mid-transfer):
  - all valid and dirty bits cleared; state IDLE.
  - done, drequest, dwrenable = 0; rdata, daddr, dwdata = 0.
  - any in-flight arbiter transaction is abandoned.
- States: IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESP.
- IDLE, enable=1 sampled at a clock edge:
  - Hit (valid and tag match), load: rdata <= word; go to RESP.
  - Hit, store: word <= wdata, dirty <= 1; go to RESP.
  - Miss, victim valid and dirty: go to WB_REQ.
  - Miss otherwise: go to FILL_REQ.
- WB_REQ: drequest=1, dwrenable=1, daddr = victim line address, dwdata = victim line. On dreqack go to WB_WAIT.
- WB_WAIT: drequest=0. On ddone go to FILL_REQ.
- FILL_REQ: drequest=1, dwrenable=0, daddr = {addr[63:6], 6'b0}. On dreqack go to FILL_WAIT.
- FILL_WAIT: drequest=0. On ddone:
  - install drdata; valid=1, dirty=0, tag written.
  - perform the pending load/store exactly as a hit in the same edge; go to RESP.
- dreqack and ddone in the same cycle: the transfer counts as complete; take the WAIT-state ddone action directly.
- RESP: done=1 for exactly one cycle; enable is ignored; return to IDLE. Requester must drop enable by the cycle after done, otherwise it is a new request.
- Latency:
  - hit: done asserted 1 cycle after the enable edge.
  - miss: done asserted 1 cycle after the fill's ddone.
- rdata holds its last value until the next load completes.
- drequest is never asserted outside the REQ states.
- dwdata and daddr are stable from WB_REQ entry until dreqack.

Optional Feature:
- Macro DCACHE_WRITE_THROUGH_EN.
- Defined:
  - no dirty bits; evictions never write back (a miss goes straight to FILL_REQ).
  - every store, after updating its line (hit or post-fill), issues a line write of the updated line via WB_REQ/WB_WAIT.
  - done is pulsed only after that write's ddone.
- Undefined: write-back behaviour as above.

Test Plan:
- Load miss to empty cache, addr 0x1008, fill line word1 = 0xDEADBEEF → drequest with dwrenable=0, daddr=0x1000; done 1 cycle after ddone; rdata=0xDEADBEEF.
- Repeat the same load → no drequest; done exactly 1 cycle after enable; rdata=0xDEADBEEF.
- Store 0x1234 to 0x1010, then load 0x1010 → both hit; rdata=0x1234; no memory traffic.
- Load to 0x1000 + 64*NUM_LINES (conflicting index) after the dirty store:
  - write-back first: dwrenable=1, daddr=0x1000, dwdata[191:128]=0x1234.
  - then fill read; done after the fill.
- dreqack and ddone asserted in the same cycle during a fill → completes normally; done 1 cycle later.
- Assert reset during FILL_WAIT → drequest=0, done=0 immediately; the following load to the same address misses again.
